// File: rtl/pl_io_pkg.sv
// Shared definitions for the pipelined computer's memory-mapped I/O controller.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
//
// Contents: register word indices, seven-segment table, blank pattern,
// debounce FSM state type and the hex encoder function.
package pl_io_pkg;

  localparam int REG_SW        = 0;
  localparam int REG_KEY_STATE = 1;
  localparam int REG_KEY_EVENT = 2;
  localparam int REG_HEX_VAL   = 3;
  localparam int REG_HEX_BLANK = 4;
  localparam int REG_LED       = 5;
  localparam int REG_IRQ_MASK  = 6;

  // Active-low segments, seg a = bit 0. Entry 15 is the leftmost element.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  typedef enum logic [1:0] {
    DB_UP     = 2'd0,
    DB_CHK_DN = 2'd1,
    DB_DOWN   = 2'd2,
    DB_CHK_UP = 2'd3
  } db_state_t;

  function automatic logic [6:0] hex_encode(input logic [3:0] val, input logic blank);
    return blank ? BLANK_SEG : SEG_TAB[val];
  endfunction

endpackage

// File: rtl/pl_key_debounce.sv
// Per-key synchroniser and debouncer for an active-low push button.
// Latency: 2-cycle sync, then DEBOUNCE_CYCLES+1 stable samples before a state change.
// Backpressure: none; free-running on every clock.
//
// Ports: clock, resetn (async active-low), key_n (raw pin, 0 = pressed),
//        pressed (debounced level), press_pulse (1 cycle on each accepted press).
module pl_key_debounce
  import pl_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync;
  logic       sample;
  db_state_t  state;
  logic [7:0] cnt;

  assign sample = sync[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync        <= 2'b11;
      state       <= DB_UP;
      cnt         <= 8'd0;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync        <= {sync[0], key_n};
      press_pulse <= 1'b0;
      case (state)
        DB_UP: begin
          if (!sample) begin
            state <= DB_CHK_DN;
            cnt   <= 8'd0;
          end
        end
        DB_CHK_DN: begin
          if (sample) begin
            state <= DB_UP;
          end else if (cnt >= CNT_LAST) begin
            state       <= DB_DOWN;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        DB_DOWN: begin
          if (sample) begin
            state <= DB_CHK_UP;
            cnt   <= 8'd0;
          end
        end
        DB_CHK_UP: begin
          if (!sample) begin
            state <= DB_DOWN;
          end else if (cnt >= CNT_LAST) begin
            state   <= DB_UP;
            pressed <= 1'b0;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= DB_UP;
      endcase
    end
  end

endmodule

// File: rtl/pl_io_ctrl.sv
// Memory-mapped I/O controller: switches, debounced keys, hex displays, LEDs.
// Latency: loads registered (1 cycle); stores reach io_out 1 cycle later.
// Backpressure: none; every cpu_we / cpu_re strobe is accepted in its cycle.
//
// Ports: clock, resetn, io_in[12:0] (sw[9:0], key_n[2:0]), cpu_addr/cpu_wdata/
//        cpu_we/cpu_re/cpu_rdata (CPU port), io_out[44:0] (6 hex digits + 3 LEDs),
//        key_irq. Optional macro PL_IO_KEY_IRQ_EN adds IRQ_MASK (word 6) and key_irq.
module pl_io_ctrl
  import pl_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [12:0]       io_in,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [31:0]       cpu_rdata,
  output logic [44:0]       io_out,
  output logic              key_irq
);

  logic [9:0]  sw_s1, sw_s2;
  logic [2:0]  key_pressed, key_pulse;
  logic [23:0] hex_val;
  logic [5:0]  hex_blank;
  logic [2:0]  led;
  logic [2:0]  key_event;
  logic [31:0] addr_idx;
  logic [31:0] rd_dat;
  logic [2:0]  w1c_mask;
  logic        wdata_unused;

  assign addr_idx     = 32'(cpu_addr);
  assign wdata_unused = ^cpu_wdata[31:24];

  for (genvar i = 0; i < 3; i++) begin : g_key
    pl_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock       (clock),
      .resetn      (resetn),
      .key_n       (io_in[10+i]),
      .pressed     (key_pressed[i]),
      .press_pulse (key_pulse[i])
    );
  end

`ifdef PL_IO_KEY_IRQ_EN
  logic [2:0] irq_mask;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_mask <= 3'd0;
      key_irq  <= 1'b0;
    end else begin
      if (cpu_we && addr_idx == REG_IRQ_MASK) irq_mask <= cpu_wdata[2:0];
      key_irq <= |(key_event & irq_mask);
    end
  end
`else
  logic [2:0] irq_mask;
  assign irq_mask = 3'd0;
  assign key_irq  = 1'b0;
`endif

  always_comb begin
    rd_dat = 32'd0;
    case (addr_idx)
      REG_SW:        rd_dat = {22'd0, sw_s2};
      REG_KEY_STATE: rd_dat = {29'd0, key_pressed};
      REG_KEY_EVENT: rd_dat = {29'd0, key_event};
      REG_HEX_VAL:   rd_dat = {8'd0, hex_val};
      REG_HEX_BLANK: rd_dat = {26'd0, hex_blank};
      REG_LED:       rd_dat = {29'd0, led};
      REG_IRQ_MASK:  rd_dat = {29'd0, irq_mask};
      default:       rd_dat = 32'd0;
    endcase
  end

  assign w1c_mask = (cpu_we && addr_idx == REG_KEY_EVENT) ? cpu_wdata[2:0] : 3'd0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1     <= 10'd0;
      sw_s2     <= 10'd0;
      hex_val   <= 24'd0;
      hex_blank <= 6'h3F;
      led       <= 3'd0;
      key_event <= 3'd0;
      cpu_rdata <= 32'd0;
    end else begin
      sw_s1 <= io_in[9:0];
      sw_s2 <= sw_s1;
      // A press landing in the same cycle as its W1C must not be lost.
      key_event <= (key_event & ~w1c_mask) | key_pulse;
      if (cpu_re) cpu_rdata <= rd_dat;
      if (cpu_we) begin
        case (addr_idx)
          REG_HEX_VAL:   hex_val   <= cpu_wdata[23:0];
          REG_HEX_BLANK: hex_blank <= cpu_wdata[5:0];
          REG_LED:       led       <= cpu_wdata[2:0];
          default:       ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < 6; k++) begin : g_hex
    assign io_out[7*k +: 7] = hex_encode(hex_val[4*k +: 4], hex_blank[k]);
  end
  assign io_out[44:42] = led;

endmodule

// File: tb/tb_pl_io_ctrl.sv
module tb_pl_io_ctrl;

  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic [12:0] io_in;
  logic [2:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic [44:0] io_out;
  logic        key_irq;

  always #5 clock = ~clock;

  pl_io_ctrl #(.DEBOUNCE_CYCLES(DC), .ADDR_W(3)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .io_in     (io_in),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .io_out    (io_out),
    .key_irq   (key_irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: board-level behaviour, one update per rising edge.
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [9:0]  m_sw1, m_sw2;
  logic [2:0]  m_k1, m_k2;
  logic [2:0]  m_pressed, m_pulse, m_event, m_led, m_mask;
  int          m_run [3];
  logic [23:0] m_hex;
  logic [5:0]  m_blank;
  logic        m_irq;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_k1 = 3'b111; m_k2 = 3'b111;
    m_pressed = '0; m_pulse = '0; m_event = '0; m_led = '0; m_mask = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_hex = '0; m_blank = 6'h3F; m_irq = 1'b0; m_rdata = '0;
  endtask

  function automatic logic [44:0] exp_io_out();
    logic [44:0] r;
    for (int k = 0; k < 6; k++)
      r[7*k +: 7] = m_blank[k] ? 7'h7F : seg_tab[m_hex[4*k +: 4]];
    r[44:42] = m_led;
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0: return {22'd0, m_sw2};
      1: return {29'd0, m_pressed};
      2: return {29'd0, m_event};
      3: return {8'd0, m_hex};
      4: return {26'd0, m_blank};
      5: return {29'd0, m_led};
`ifdef PL_IO_KEY_IRQ_EN
      6: return {29'd0, m_mask};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    int a;
    logic [2:0] w1c, np;
    logic low;
    a = int'(cpu_addr);
    if (cpu_re) m_rdata = model_read(a);
`ifdef PL_IO_KEY_IRQ_EN
    m_irq = |(m_event & m_mask);
`endif
    w1c = (cpu_we && a == 2) ? cpu_wdata[2:0] : 3'd0;
    np = '0;
    // A key flips after DC+1 consecutive synchronised samples disagreeing with it.
    for (int i = 0; i < 3; i++) begin
      low = !m_k2[i];
      if (low != m_pressed[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == DC + 1) begin
        m_pressed[i] = low;
        m_run[i] = 0;
        np[i] = low;
      end
    end
    m_event = (m_event & ~w1c) | m_pulse;
    m_pulse = np;
    if (cpu_we) begin
      case (a)
        3: m_hex = cpu_wdata[23:0];
        4: m_blank = cpu_wdata[5:0];
        5: m_led = cpu_wdata[2:0];
`ifdef PL_IO_KEY_IRQ_EN
        6: m_mask = cpu_wdata[2:0];
`endif
        default: ;
      endcase
    end
    m_k2 = m_k1; m_k1 = io_in[12:10];
    m_sw2 = m_sw1; m_sw1 = io_in[9:0];
  endtask

  task automatic step();
    @(posedge clock);
    if (resetn) model_edge();
    @(negedge clock);
    chk("io_out", io_out, exp_io_out());
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("key_irq", key_irq, m_irq);
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cpu_addr = 3'(a); cpu_wdata = d; cpu_we = 1'b1;
    step();
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    cpu_addr = 3'(a); cpu_re = 1'b1;
    step();
    chk(tag, cpu_rdata, exp);
  endtask

  task automatic press_release(input int k, input int hold);
    io_in[10+k] = 1'b0;
    repeat (hold) step();
    io_in[10+k] = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    int n;
    resetn = 1'b0; io_in = {3'b111, 10'd0};
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    model_reset();
    @(negedge clock); @(negedge clock);
    chk("rst_io_out", io_out, {3'b000, 42'h3FF_FFFF_FFFF});
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_irq", key_irq, 1'b0);
    resetn = 1'b1;

    rd_chk("rst_blank", 4, 32'h3F);

    wr(3, 32'h0000C0DE);
    wr(4, 32'h30);
    chk("hex_segs", io_out[41:0], {7'h7F, 7'h7F, 7'h46, 7'h40, 7'h21, 7'h06});
    wr(5, 32'h5);
    chk("led", io_out[44:42], 3'b101);

    io_in[9:0] = 10'h2A5;
    rd_chk("sw_early", 0, 32'h0);
    step();
    rd_chk("sw_synced", 0, 32'h2A5);

    press_release(1, 3);
    rd_chk("short_glitch", 2, 32'h0);
    io_in[11] = 1'b0;
    repeat (10) step();
    rd_chk("key_state_dn", 1, 32'h2);
    rd_chk("key_event_dn", 2, 32'h2);
    io_in[11] = 1'b1;
    repeat (12) step();
    rd_chk("key_state_up", 1, 32'h0);
    rd_chk("key_event_sticky", 2, 32'h2);

    wr(2, 32'h2);
    rd_chk("w1c_clear", 2, 32'h0);
    io_in[11] = 1'b0;
    n = 0;
    while (!m_pulse[1] && n < 20) begin step(); n++; end
    if (!m_pulse[1]) chk("pulse_timeout", 1'b0, 1'b1);
    wr(2, 32'h2);
    rd_chk("w1c_race_set_wins", 2, 32'h2);
    io_in[11] = 1'b1;
    repeat (12) step();
    wr(2, 32'h2);
    rd_chk("w1c_later", 2, 32'h0);

`ifdef PL_IO_KEY_IRQ_EN
    wr(6, 32'h4);
    rd_chk("irq_mask", 6, 32'h4);
    press_release(0, 10);
    chk("irq_masked", key_irq, 1'b0);
    io_in[12] = 1'b0;
    n = 0;
    while (!m_event[2] && n < 20) begin step(); n++; end
    if (!m_event[2]) chk("event_timeout", 1'b0, 1'b1);
    step();
    chk("irq_set", key_irq, 1'b1);
    io_in[12] = 1'b1;
    wr(2, 32'h5);
    step();
    chk("irq_clr", key_irq, 1'b0);
`else
    wr(6, 32'h7);
    rd_chk("word6_zero", 6, 32'h0);
    press_release(2, 10);
    chk("irq_tied", key_irq, 1'b0);
`endif

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) io_in[9:0] = 10'($urandom);
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 9) == 0) io_in[10+k] = ~io_in[10+k];
      cpu_addr  = 3'($urandom_range(0, 7));
      cpu_wdata = $urandom;
      cpu_re    = ($urandom_range(0, 1) == 1);
      cpu_we    = ($urandom_range(0, 3) == 0);
      if (c == 700) begin
        cpu_we = 1'b0; cpu_re = 1'b0;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_io_out", io_out, {3'b000, 42'h3FF_FFFF_FFFF});
        chk("mid_rst_irq", key_irq, 1'b0);
        step();
        resetn = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
